// File: rtl/mult_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl_pkg
//   Shared definitions for the digit-serial multiplier controller:
//   digit width of the shared combinational multiplier, controller state
//   encoding, and a helper that derives the digit count from operand width.
// -----------------------------------------------------------------------------
package mult_seq_ctrl_pkg;

  // Width of one operand digit handled by the shared Multiplier_2.
  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of DIGIT_W-bit digits in a w-bit operand.
  function automatic int num_digits(input int w);
    return w / DIGIT_W;
  endfunction

endpackage

// File: rtl/mult_seq_ctrl_multiplier_2.sv
// -----------------------------------------------------------------------------
// Multiplier_2
//   Existing 2-bit x 2-bit unsigned combinational multiplier shared by the
//   controller.
//   Ports:
//     x  in  2  multiplicand digit
//     y  in  2  multiplier digit
//     z  out 4  product x*y
// -----------------------------------------------------------------------------
module Multiplier_2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] z
);

  // Widen before multiplying so the full 4-bit product is kept.
  assign z = {2'b00, x} * {2'b00, y};

endmodule

// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//   Computes a W x W unsigned product by stepping through all N*N digit
//   pairs (N = W/2), one per clock, through a single shared Multiplier_2.
//   Each 4-bit partial product is shifted into place and added into a
//   2W-bit accumulator. start/ready/done handshake toward the requester.
//   Ports:
//     clk    in   1   rising-edge clock
//     rst    in   1   synchronous active-high reset
//     start  in   1   request, accepted only while ready=1
//     a      in   W   multiplicand, latched on acceptance
//     b      in   W   multiplier, latched on acceptance
//     ready  out  1   high in IDLE
//     done   out  1   one-cycle pulse when p holds a new result
//     p      out  2W  product, held until the next completion
// -----------------------------------------------------------------------------
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           ready,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int N  = num_digits(W);
  localparam int NN = N * N;
  localparam int KW = (NN > 1) ? $clog2(NN) : 1;
  localparam int PW = 2 * W;

  state_e r_state;
  state_e w_next;

  logic [W-1:0]              r_a;
  logic [W-1:0]              r_b;
  logic [PW-1:0]             r_acc;
  logic [PW-1:0]             r_p;
  logic [KW-1:0]             r_k;

  logic [DIGIT_W-1:0]        w_x;
  logic [DIGIT_W-1:0]        w_y;
  logic [2*DIGIT_W-1:0]      w_z;
  logic [PW-1:0]             w_term;
  logic [PW-1:0]             w_sum;
  logic                      w_last;
  int                        w_i;
  int                        w_j;

  // ---------------------------------------------------------------------------
  // Digit selection and accumulation. Step k walks digit i of a (outer) and
  // digit j of b (inner); the partial product lands at bit 2(i+j).
  // ---------------------------------------------------------------------------
  always_comb begin
    w_i    = int'(r_k) / N;
    w_j    = int'(r_k) % N;
    w_x    = r_a[DIGIT_W*w_i +: DIGIT_W];
    w_y    = r_b[DIGIT_W*w_j +: DIGIT_W];
    w_term = PW'(w_z) << (DIGIT_W * (w_i + w_j));
    w_sum  = r_acc + w_term;
    w_last = (r_k == KW'(NN - 1));
  end

  Multiplier_2 u_multiplier_2 (
    .x (w_x),
    .y (w_y),
    .z (w_z)
  );

  // ---------------------------------------------------------------------------
  // Next-state and decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next = r_state;
    ready  = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_next = ST_CALC;
      end
      ST_CALC: begin
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and datapath. Reset has priority over a same-edge start,
  // and a reset mid-calculation discards the partial sum without a done.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_p     <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_k   <= '0;
          end
        end
        ST_CALC: begin
          r_acc <= w_sum;
          // k stops at the last step instead of wrapping.
          if (w_last) r_p <= w_sum;
          else        r_k <= r_k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign p = r_p;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_ctrl
//   Drives a W=8 and a W=4 instance. Expected products come from plain
//   integer multiplication; expected latency is (W/2)^2 cycles after the
//   accepting edge. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        ready8, done8;
  logic [15:0] p8;

  logic        start4;
  logic [3:0]  a4, b4;
  logic        ready4, done4;
  logic [7:0]  p4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.W(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .ready (ready8),
    .done  (done8),
    .p     (p8)
  );

  mult_seq_ctrl #(.W(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .ready (ready4),
    .done  (done4),
    .p     (p4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- W=8 helpers ----------------
  task automatic wait_ready8();
    int t = 0;
    while (!ready8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check("ready8_timeout", 32'(ready8), 32'd1);
  endtask

  // Issues one request; lat counts edges after the accepting edge until done.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                      output int lat, output logic [15:0] res);
    wait_ready8();
    start8 = 1'b1;
    a8     = ia;
    b8     = ib;
    @(negedge clk);
    start8 = 1'b0;
    lat    = 0;
    while (!done8 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    res = p8;
  endtask

  task automatic do8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                     input logic [15:0] exp);
    int          lat;
    logic [15:0] res;
    run8(ia, ib, lat, res);
    check({tag, "_p"}, 32'(res), 32'(exp));
    check({tag, "_lat"}, lat, 32'd16);
    @(negedge clk);
    check({tag, "_done_once"}, 32'(done8), 32'd0);
    check({tag, "_ready_after"}, 32'(ready8), 32'd1);
  endtask

  // ---------------- W=4 helpers ----------------
  task automatic run4(input logic [3:0] ia, input logic [3:0] ib,
                      output int lat, output logic [7:0] res);
    int t = 0;
    while (!ready4 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) check("ready4_timeout", 32'(ready4), 32'd1);
    start4 = 1'b1;
    a4     = ia;
    b4     = ib;
    @(negedge clk);
    start4 = 1'b0;
    lat    = 0;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = p4;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, dones, first_lat, d1, d2, cyc;
    logic [15:0] pv, res8;
    logic [7:0]  ra, rb, res4;

    rst    = 1'b1;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    // start high together with rst: reset must win.
    repeat (2) @(negedge clk);
    start8 = 1'b1;
    a8     = 8'hFF;
    b8     = 8'hFF;
    @(negedge clk);
    check("rst_ready8", 32'(ready8), 32'd1);
    check("rst_done8",  32'(done8),  32'd0);
    check("rst_p8",     32'(p8),     32'd0);
    check("rst_ready4", 32'(ready4), 32'd1);
    check("rst_p4",     32'(p4),     32'd0);
    start8 = 1'b0;
    rst    = 1'b0;
    @(negedge clk);

    // Directed vectors
    do8("zero_ff", 8'h00, 8'hFF, 16'h0000);
    do8("ff_ff",   8'hFF, 8'hFF, 16'hFE01);
    do8("12_34",   8'h12, 8'h34, 16'h03A8);
    do8("a5_5a",   8'hA5, 8'h5A, 16'h3A02);

    // start pulsed mid-calculation is ignored
    wait_ready8();
    start8 = 1'b1;
    a8     = 8'h12;
    b8     = 8'h34;
    @(negedge clk);
    start8    = 1'b0;
    lat       = 0;
    dones     = 0;
    first_lat = -1;
    pv        = '0;
    repeat (40) begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin
        start8 = 1'b1;
        a8     = 8'hFF;
        b8     = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      if (done8) begin
        dones++;
        if (dones == 1) begin
          first_lat = lat;
          pv        = p8;
        end
      end
    end
    check("ign_dones", dones, 32'd1);
    check("ign_lat", first_lat, 32'd16);
    check("ign_p", 32'(pv), 32'h03A8);

    // Reset during the 7th CALC cycle
    wait_ready8();
    start8 = 1'b1;
    a8     = 8'hFF;
    b8     = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 32'(ready8), 32'd1);
    check("midrst_p",     32'(p8),     32'd0);
    check("midrst_done",  32'(done8),  32'd0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("midrst_no_done", dones, 32'd0);
    do8("after_rst", 8'h03, 8'h03, 16'h0009);

    // Back-to-back with start held high
    wait_ready8();
    start8 = 1'b1;
    a8     = 8'h10;
    b8     = 8'h10;
    @(negedge clk);
    cyc = 0;
    d1  = -1;
    d2  = -1;
    while (cyc < 60 && d2 < 0) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        if (d1 < 0) begin
          d1 = cyc;
          check("b2b_p1", 32'(p8), 32'h0100);
          a8 = 8'h02;
          b8 = 8'h80;
        end else begin
          d2 = cyc;
          check("b2b_p2", 32'(p8), 32'h0100);
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    check("b2b_lat1", d1, 32'd16);
    check("b2b_gap", d2 - d1, 32'd18);
    @(negedge clk);

    // Random operands against plain multiplication
    repeat (24) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do8("rand", ra, rb, 16'(ra) * 16'(rb));
    end

    // Exhaustive W=4
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run4(4'(ia), 4'(ib), lat, res4);
        check("w4_p", 32'(res4), 32'(ia * ib));
        check("w4_lat", lat, 32'd4);
      end
    end
    @(negedge clk);
    check("w4_ready_end", 32'(ready4), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
